// File: rtl/domain_handshake_tx.sv
// Sending side of a 4-phase req/ack crossing in the clkA domain; AckIn is resynchronized internally.
// Optional one-word pending slot enabled by defining HS_PENDING_EN.
module domain_handshake_tx #(
   parameter int DATA_W      = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clkA,
   input  logic              rst,
   input  logic              SendStb,
   input  logic [DATA_W-1:0] SendData,
   output logic              Busy,
   output logic              Done,
   output logic              Drop,
   output logic              ReqOut,
   output logic [DATA_W-1:0] DataOut,
   input  logic              AckIn
);

   typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

   state_t                 state_q, state_d;
   logic                   req_q, req_d;
   logic [DATA_W-1:0]      data_q, data_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   drop_q, drop_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ack_s;
`ifdef HS_PENDING_EN
   logic                   pend_v_q, pend_v_d;
   logic [DATA_W-1:0]      pend_d_q, pend_d_d;
`endif

   assign ack_s = sync_q[SYNC_STAGES-1];

   always_ff @(posedge clkA or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         req_q    <= 1'b0;
         data_q   <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         drop_q   <= 1'b0;
         sync_q   <= '0;
`ifdef HS_PENDING_EN
         pend_v_q <= 1'b0;
         pend_d_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         req_q    <= req_d;
         data_q   <= data_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         drop_q   <= drop_d;
         sync_q   <= {sync_q[SYNC_STAGES-2:0], AckIn};
`ifdef HS_PENDING_EN
         pend_v_q <= pend_v_d;
         pend_d_q <= pend_d_d;
`endif
      end
   end

   always_comb begin
      state_d  = state_q;
      req_d    = req_q;
      data_d   = data_q;
      done_d   = 1'b0;
      drop_d   = 1'b0;
`ifdef HS_PENDING_EN
      pend_v_d = pend_v_q;
      pend_d_d = pend_d_q;
`endif
      case (state_q)
         IDLE: begin
            if (SendStb) begin
               if (!ack_s) begin
                  data_d  = SendData;
                  req_d   = 1'b1;
                  state_d = REQ;
               end else begin
                  drop_d  = 1'b1;
               end
            end
         end
         REQ: begin
            if (ack_s) begin
               req_d   = 1'b0;
               state_d = REL;
            end
         end
         REL: begin
            if (!ack_s) begin
               done_d  = 1'b1;
               state_d = IDLE;
`ifdef HS_PENDING_EN
               if (pend_v_q) begin
                  state_d  = REQ;
                  data_d   = pend_d_q;
                  req_d    = 1'b1;
                  pend_v_d = 1'b0;
               end
`endif
            end
         end
         default: state_d = IDLE;
      endcase
      // Strobe while busy; pend_v_d already reflects a slot freed by completion this cycle.
      if (SendStb && (state_q != IDLE)) begin
`ifdef HS_PENDING_EN
         if (!pend_v_d) begin
            pend_v_d = 1'b1;
            pend_d_d = SendData;
         end else begin
            drop_d   = 1'b1;
         end
`else
         drop_d = 1'b1;
`endif
      end
      busy_d = (state_d != IDLE);
   end

   assign Busy    = busy_q;
   assign Done    = done_q;
   assign Drop    = drop_q;
   assign ReqOut  = req_q;
   assign DataOut = data_q;

endmodule

// File: tb/tb_domain_handshake_tx.sv
// Scoreboard bench for domain_handshake_tx: responder returns AckIn = ReqOut delayed 3 cycles.
`timescale 1ns/1ps
module tb_domain_handshake_tx;

   localparam int S  = 2;
   localparam int S3 = 3;

   logic       clk = 1'b0;
   logic       rst, SendStb, Busy, Done, Drop, ReqOut, AckIn;
   logic [7:0] SendData, DataOut;
   logic       rst3, stb3, busy3, done3, drop3, req3, ack3;
   logic [7:0] data3, dout3;

   logic [3:0] pipe  = '0;
   logic [3:0] pipe3 = '0;
   logic       force_en, force_val;

   int unsigned cyc = 0;
   int          tests = 0;
   int          fails = 0;

   typedef struct {
      int unsigned cyc;
      logic [7:0]  data;
      logic        busy;
   } exp_t;

   exp_t q_rise[$], q_fall[$], q_done[$], q_drop[$];

   domain_handshake_tx #(.DATA_W(8), .SYNC_STAGES(S)) dut (
      .clkA(clk), .rst(rst), .SendStb(SendStb), .SendData(SendData),
      .Busy(Busy), .Done(Done), .Drop(Drop), .ReqOut(ReqOut),
      .DataOut(DataOut), .AckIn(AckIn)
   );

   domain_handshake_tx #(.DATA_W(8), .SYNC_STAGES(S3)) dut3 (
      .clkA(clk), .rst(rst3), .SendStb(stb3), .SendData(data3),
      .Busy(busy3), .Done(done3), .Drop(drop3), .ReqOut(req3),
      .DataOut(dout3), .AckIn(ack3)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      pipe  <= {pipe[2:0], ReqOut};
      pipe3 <= {pipe3[2:0], req3};
   end
   assign AckIn = force_en ? force_val : pipe[3];
   assign ack3  = pipe3[3];

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic unexpected(input string name);
      tests++;
      fails++;
      $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
   endtask

   // Monitor: pops expectations whenever the DUT presents an event.
   logic       prev_req = 1'b0;
   logic [7:0] held = '0;
   always @(negedge clk) begin
      exp_t e;
      logic rose;
      if (rst) begin
         prev_req = 1'b0;
      end else begin
         rose = ReqOut && !prev_req;
         if (Drop) begin
            if (q_drop.size() == 0) unexpected("drop");
            else begin e = q_drop.pop_front(); chk("drop cycle", cyc, e.cyc); end
         end
         if (Done) begin
            if (q_done.size() == 0) unexpected("done");
            else begin
               e = q_done.pop_front();
               chk("done cycle", cyc, e.cyc);
               chk("busy at done", Busy, e.busy);
            end
         end
         if (!ReqOut && prev_req) begin
            if (q_fall.size() == 0) unexpected("req fall");
            else begin e = q_fall.pop_front(); chk("req fall cycle", cyc, e.cyc); end
         end
         if (rose) begin
            if (q_rise.size() == 0) unexpected("req rise");
            else begin
               e = q_rise.pop_front();
               chk("req rise cycle", cyc, e.cyc);
               chk("dataout at rise", DataOut, e.data);
            end
            held = DataOut;
         end else if (Busy) begin
            chk("dataout held", DataOut, held);
         end
         prev_req = ReqOut;
      end
   end

   task automatic push(input int kind, input int unsigned c, input logic [7:0] d, input logic b);
      exp_t e;
      e.cyc = c; e.data = d; e.busy = b;
      case (kind)
         0: q_rise.push_back(e);
         1: q_fall.push_back(e);
         2: q_done.push_back(e);
         default: q_drop.push_back(e);
      endcase
   endtask

   task automatic expect_xfer(input int unsigned t0, input logic [7:0] d);
      push(0, t0 + 1, d, 1'b0);
      push(1, t0 + 5 + S, 8'h00, 1'b0);
      push(2, t0 + 9 + 2 * S, 8'h00, 1'b0);
   endtask

   task automatic strobe(input logic [7:0] d);
      SendStb  = 1'b1;
      SendData = d;
      @(negedge clk);
      SendStb  = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int unsigned t0;
      int          n;
      rst = 1'b1; rst3 = 1'b1;
      SendStb = 1'b0; SendData = '0; stb3 = 1'b0; data3 = '0;
      force_en = 1'b0; force_val = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset busy", Busy, 0);
      chk("reset done", Done, 0);
      chk("reset drop", Drop, 0);
      chk("reset req", ReqOut, 0);
      chk("reset data", DataOut, 0);
      rst = 1'b0; rst3 = 1'b0;
      repeat (2) @(negedge clk);

      // Single transfer
      t0 = cyc; expect_xfer(t0, 8'hA5); strobe(8'hA5);
      repeat (16) @(negedge clk);

`ifdef HS_PENDING_EN
      t0 = cyc;
      push(0, t0 + 1, 8'h11, 1'b0);
      push(1, t0 + 7, 8'h00, 1'b0);
      push(2, t0 + 13, 8'h00, 1'b1);
      push(0, t0 + 13, 8'h22, 1'b0);
      push(1, t0 + 19, 8'h00, 1'b0);
      push(2, t0 + 25, 8'h00, 1'b0);
      push(3, t0 + 3, 8'h00, 1'b0);
      strobe(8'h11); strobe(8'h22); strobe(8'h33);
      repeat (28) @(negedge clk);
`else
      t0 = cyc; expect_xfer(t0, 8'h11); push(3, t0 + 4, 8'h00, 1'b0);
      strobe(8'h11);
      repeat (2) @(negedge clk);
      strobe(8'h22);
      repeat (16) @(negedge clk);
`endif

      // Reset in the middle of REQ
      t0 = cyc; push(0, t0 + 1, 8'h77, 1'b0); strobe(8'h77);
      repeat (2) @(negedge clk);
      chk("req before reset", ReqOut, 1);
      #2 rst = 1'b1;
      #1 chk("req drops on reset", ReqOut, 0);
      repeat (6) @(negedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      chk("post-reset busy", Busy, 0);
      chk("post-reset req", ReqOut, 0);
      chk("post-reset data", DataOut, 0);
      t0 = cyc; expect_xfer(t0, 8'h5A); strobe(8'h5A);
      repeat (16) @(negedge clk);

      // Stale ack held through reset release
      force_en = 1'b1; force_val = 1'b1;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      #2 rst = 1'b0;
      repeat (4) @(negedge clk);
      t0 = cyc; push(3, t0 + 1, 8'h00, 1'b0); strobe(8'h33);
      @(negedge clk);
      chk("stale req stays low", ReqOut, 0);
      chk("stale busy stays low", Busy, 0);
      force_en = 1'b0;
      repeat (3) @(negedge clk);
      t0 = cyc; expect_xfer(t0, 8'h44); strobe(8'h44);
      repeat (16) @(negedge clk);

      // Three-stage synchronizer instance
      t0 = cyc; stb3 = 1'b1; data3 = 8'hC3;
      @(negedge clk); stb3 = 1'b0;
      chk("s3 req rise", req3, 1);
      chk("s3 data", dout3, 8'hC3);
      n = 0;
      while (req3 && n < 20) begin @(negedge clk); n++; end
      chk("s3 req fall cycle", cyc, t0 + 5 + S3);
      n = 0;
      while (!done3 && n < 20) begin @(negedge clk); n++; end
      chk("s3 done cycle", cyc, t0 + 9 + 2 * S3);
      chk("s3 busy at done", busy3, 0);
      chk("s3 data held", dout3, 8'hC3);
      repeat (3) @(negedge clk);

      chk("leftover rise", q_rise.size(), 0);
      chk("leftover fall", q_fall.size(), 0);
      chk("leftover done", q_done.size(), 0);
      chk("leftover drop", q_drop.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
